// File: rtl/fpio_fifo_wr_arb.sv
// rtl/fpio_fifo_wr_arb.sv - round-robin burst arbiter sharing one fpio FIFO write port
module fpio_fifo_wr_arb #(
  parameter int N_REQ      = 4,
  parameter int FIFO_BITS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 8,
  localparam int LEN_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic [N_REQ-1:0]            req,
  input  logic [N_REQ*LEN_W-1:0]      req_len,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [N_REQ-1:0]            req_data_en,
  output logic [N_REQ-1:0]            gnt,
  output logic [N_REQ-1:0]            req_data_ack,
  output logic [N_REQ-1:0]            req_done,
  input  logic [FIFO_BITS-1:0]        fifo_avail,
  output logic [DATA_WIDTH-1:0]       fifo_data,
  output logic                        fifo_data_en,
  input  logic                        fifo_data_ack
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CMP_W = (LEN_W > FIFO_BITS) ? LEN_W : FIFO_BITS;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [N_REQ-1:0]   done_q, done_d;

  logic [N_REQ-1:0]   elig;
  logic [LEN_W-1:0]   len_i;
  logic               found;
  logic [IDX_W-1:0]   win;
  logic               xfer;

  assign gnt      = gnt_q;
  assign req_done = done_q;

  // A requester is eligible only if its whole burst is legal and fits in the FIFO right now
  always_comb begin
    elig  = '0;
    len_i = '0;
    for (int i = 0; i < N_REQ; i++) begin
      len_i   = req_len[i*LEN_W +: LEN_W];
      elig[i] = req[i] && (len_i != '0) && (len_i <= LEN_W'(MAX_BURST)) &&
                (CMP_W'(len_i) <= CMP_W'(fifo_avail));
    end
  end

  // Pick the first eligible requester at or after the round-robin pointer, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!found && elig[(int'(rr_q) + k) % N_REQ]) begin
        found = 1'b1;
        win   = IDX_W'((int'(rr_q) + k) % N_REQ);
      end
    end
  end

  // Owner's stream goes to the FIFO; nothing is driven in IDLE or while reset is held
  always_comb begin
    fifo_data    = '0;
    fifo_data_en = 1'b0;
    req_data_ack = '0;
    if (reset_n && (state_q == BURST)) begin
      fifo_data             = req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
      fifo_data_en          = req_data_en[owner_q];
      req_data_ack[owner_q] = fifo_data_ack && req_data_en[owner_q];
    end
  end

  assign xfer = fifo_data_en && fifo_data_ack;

  // Next-state: capture a winner in IDLE, count beats in BURST, release after the last beat
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = BURST;
          owner_d    = win;
          len_d      = req_len[win*LEN_W +: LEN_W];
          cnt_d      = '0;
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
        end
      end
      BURST: begin
        if (xfer) begin
          if ((cnt_q + 1'b1) == len_q) begin
            state_d         = IDLE;
            gnt_d           = '0;
            cnt_d           = '0;
            done_d[owner_q] = 1'b1;
            rr_d            = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(owner_q + 1'b1);
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset drops any burst in flight without a done pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_fpio_fifo_wr_arb.sv
// tb/tb_fpio_fifo_wr_arb.sv - self-checking bench for fpio_fifo_wr_arb
module tb_fpio_fifo_wr_arb;

  localparam int N  = 4;
  localparam int FB = 4;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int LW = $clog2(MB + 1);

  logic            clock = 1'b0;
  logic            reset_n;
  logic [N-1:0]    req;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_data_en;
  logic [N-1:0]    gnt;
  logic [N-1:0]    req_data_ack;
  logic [N-1:0]    req_done;
  logic [FB-1:0]   fifo_avail;
  logic [DW-1:0]   fifo_data;
  logic            fifo_data_en;
  logic            fifo_data_ack;

  int tests = 0;
  int fails = 0;
  int n_xfer = 0;
  int word_idx [N];
  int pushed [N];
  logic [DW-1:0] exp_q [$];

  fpio_fifo_wr_arb #(.N_REQ(N), .FIFO_BITS(FB), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clock(clock), .reset_n(reset_n), .req(req), .req_len(req_len),
    .req_data(req_data), .req_data_en(req_data_en), .gnt(gnt),
    .req_data_ack(req_data_ack), .req_done(req_done), .fifo_avail(fifo_avail),
    .fifo_data(fifo_data), .fifo_data_en(fifo_data_en), .fifo_data_ack(fifo_data_ack)
  );

  always #5 clock = ~clock;

  // Each requester presents its identity and running word number
  always_comb begin
    req_data = '0;
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {8'(i), 24'(word_idx[i])};
  end

  function automatic logic [DW-1:0] word(input int r, input int n);
    return {8'(r), 24'(n)};
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic push_burst(input int r, input int len);
    for (int k = 0; k < len; k++) begin
      exp_q.push_back(word(r, pushed[r]));
      pushed[r]++;
    end
  endtask

  task automatic set_len(input int r, input int l);
    req_len[r*LW +: LW] = LW'(l);
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; req = '0; req_len = '0; req_data_en = '0;
    fifo_avail = '0; fifo_data_ack = 1'b1;
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  // Scoreboard monitor: every FIFO transfer must match the next expected word
  task automatic monitor();
    logic [DW-1:0] e;
    int o;
    forever begin
      @(negedge clock);
      if (reset_n) begin
        tests++;
        if (((req_data_ack & ~gnt) !== '0) || ((gnt === '0) && (fifo_data_en !== 1'b0))) begin
          fails++;
          $display("FAIL mon_idle_nonowner: ack=%b gnt=%b fifo_data_en=%b, required no ack outside owner and no data_en in idle",
                   req_data_ack, gnt, fifo_data_en);
        end
        if (fifo_data_en && fifo_data_ack) begin
          n_xfer++;
          tests++;
          o = 0;
          for (int i = 0; i < N; i++) if (gnt[i]) o = i;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL mon_unexpected_xfer: got %h, required no transfer", fifo_data);
          end else begin
            e = exp_q.pop_front();
            if (fifo_data !== e) begin
              fails++;
              $display("FAIL mon_data: got %h, required %h", fifo_data, e);
            end
          end
          @(posedge clock);
          word_idx[o]++;
        end
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; req = '1; req_data_en = '1; fifo_avail = 4'd15; fifo_data_ack = 1'b1;
    for (int i = 0; i < N; i++) set_len(i, 1);
    cyc(); cyc();
    tests++;
    if ((gnt !== '0) || (req_done !== '0) || (fifo_data_en !== 1'b0) ||
        (req_data_ack !== '0) || (fifo_data !== '0)) begin
      fails++;
      $display("FAIL reset_outputs: gnt=%b done=%b en=%b ack=%b data=%h, required all zero",
               gnt, req_done, fifo_data_en, req_data_ack, fifo_data);
    end
    req = '0; req_data_en = '0;
    reset_n = 1'b1;
    cyc();
    tests++;
    if (gnt !== '0) begin fails++; $display("FAIL reset_release_gnt: got %b, required 0000", gnt); end
  endtask

  task automatic test_single_burst();
    set_len(2, 3); fifo_avail = 4'd8; req = 4'b0100; req_data_en = '1; fifo_data_ack = 1'b1;
    push_burst(2, 3);
    #1;
    tests++;
    if (gnt !== '0) begin fails++; $display("FAIL single_pre_gnt: got %b, required 0000", gnt); end
    cyc();
    tests++;
    if (gnt !== 4'b0100) begin fails++; $display("FAIL single_gnt: got %b, required 0100", gnt); end
    req = '0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if ((req_data_ack !== 4'b0100) || (req_done !== '0)) begin
        fails++;
        $display("FAIL single_ack_beat%0d: ack=%b done=%b, required ack 0100 done 0000", k, req_data_ack, req_done);
      end
      cyc();
    end
    tests++;
    if ((gnt !== '0) || (req_done !== 4'b0100)) begin
      fails++;
      $display("FAIL single_done: gnt=%b done=%b, required gnt 0000 done 0100", gnt, req_done);
    end
    cyc();
    tests++;
    if (req_done !== '0) begin fails++; $display("FAIL single_done_pulse: got %b, required 0000", req_done); end
    set_len(0, 1); set_len(3, 1); req = 4'b1001;
    push_burst(3, 1); push_burst(0, 1);
    cyc();
    tests++;
    if (gnt !== 4'b1000) begin fails++; $display("FAIL single_rr_ptr3: got %b, required 1000", gnt); end
    req = 4'b0001;
    cyc(); cyc();
    tests++;
    if (gnt !== 4'b0001) begin fails++; $display("FAIL single_rr_wrap: got %b, required 0001", gnt); end
    req = '0;
    cyc(); cyc();
  endtask

  task automatic test_round_robin();
    int order [5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] exp_g [17];
    do_reset();
    for (int i = 0; i < N; i++) set_len(i, 2);
    fifo_avail = 4'd15; req_data_en = '1; fifo_data_ack = 1'b1;
    exp_g[0] = '0;
    for (int b = 0; b < 5; b++) begin
      push_burst(order[b], 2);
      exp_g[1+3*b] = oh(order[b]);
      exp_g[2+3*b] = oh(order[b]);
      exp_g[3+3*b] = '0;
    end
    exp_g[16] = '0;
    req = '1;
    for (int k = 0; k < 17; k++) begin
      #1;
      tests++;
      if (gnt !== exp_g[k]) begin
        fails++;
        $display("FAIL rr_gnt_cycle%0d: got %b, required %b", k, gnt, exp_g[k]);
      end
      if (k == 13) req = '0;
      cyc();
    end
  endtask

  task automatic test_space_gating();
    int t;
    do_reset();
    set_len(0, 5); set_len(1, 2); fifo_avail = 4'd3; req = 4'b0011; req_data_en = '1;
    push_burst(1, 2);
    cyc();
    tests++;
    if (gnt !== 4'b0010) begin fails++; $display("FAIL space_skip0: got %b, required 0010", gnt); end
    req = 4'b0001;
    cyc(); cyc();
    tests++;
    if ((req_done !== 4'b0010) || (gnt !== '0)) begin
      fail_line("space_done1", gnt, req_done);
    end
    cyc();
    tests++;
    if (gnt !== '0) begin fails++; $display("FAIL space_hold0: got %b, required 0000", gnt); end
    fifo_avail = 4'd5;
    push_burst(0, 5);
    cyc();
    tests++;
    if (gnt !== 4'b0001) begin fails++; $display("FAIL space_grant0: got %b, required 0001", gnt); end
    req = '0;
    t = 0;
    while ((req_done[0] !== 1'b1) && (t < 20)) begin cyc(); t++; end
    tests++;
    if (t != 5) begin fails++; $display("FAIL space_burst0_len: done after %0d cycles, required 5", t); end
    cyc();
  endtask

  task automatic fail_line(input string name, input logic [N-1:0] g, input logic [N-1:0] d);
    fails++;
    $display("FAIL %s: gnt=%b done=%b, required gnt 0000 done 0010", name, g, d);
  endtask

  task automatic test_illegal_len();
    fifo_avail = 4'd15; req_data_en = '1;
    set_len(1, 0); req = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      cyc();
      tests++;
      if (gnt !== '0) begin fails++; $display("FAIL illegal_len0_c%0d: got %b, required 0000", k, gnt); end
    end
    set_len(1, MB + 1);
    for (int k = 0; k < 6; k++) begin
      cyc();
      tests++;
      if (gnt !== '0) begin fails++; $display("FAIL illegal_len9_c%0d: got %b, required 0000", k, gnt); end
    end
    set_len(3, 1); req = 4'b1010;
    push_burst(3, 1);
    cyc();
    tests++;
    if (gnt !== 4'b1000) begin fails++; $display("FAIL illegal_grant3: got %b, required 1000", gnt); end
    req = 4'b0010;
    cyc();
    for (int k = 0; k < 4; k++) begin
      cyc();
      tests++;
      if (gnt !== '0) begin fails++; $display("FAIL illegal_after3_c%0d: got %b, required 0000", k, gnt); end
    end
    req = '0;
    cyc();
  endtask

  task automatic test_stalls();
    int en_p  [7] = '{1, 0, 1, 1, 0, 1, 1};
    int ack_p [7] = '{1, 1, 0, 1, 1, 1, 1};
    int x0;
    logic [N-1:0] e;
    set_len(2, 4); fifo_avail = 4'd15; req = 4'b0100; req_data_en = '1; fifo_data_ack = 1'b1;
    push_burst(2, 4);
    cyc();
    tests++;
    if (gnt !== 4'b0100) begin fails++; $display("FAIL stall_gnt: got %b, required 0100", gnt); end
    req = '0;
    x0 = n_xfer;
    for (int k = 0; k < 7; k++) begin
      req_data_en[2] = en_p[k][0];
      fifo_data_ack  = ack_p[k][0];
      #1;
      e = (en_p[k] != 0 && ack_p[k] != 0) ? 4'b0100 : 4'b0000;
      tests++;
      if ((req_data_ack !== e) || (req_done !== '0)) begin
        fails++;
        $display("FAIL stall_ack_c%0d: ack=%b done=%b, required ack %b done 0000", k, req_data_ack, req_done, e);
      end
      cyc();
    end
    fifo_data_ack = 1'b1; req_data_en = '1;
    tests++;
    if ((req_done !== 4'b0100) || (gnt !== '0) || (n_xfer - x0 != 4)) begin
      fails++;
      $display("FAIL stall_done: done=%b gnt=%b xfers=%0d, required done 0100 gnt 0000 xfers 4",
               req_done, gnt, n_xfer - x0);
    end
    cyc();
  endtask

  task automatic test_reset_mid_burst();
    int t;
    set_len(1, 4); fifo_avail = 4'd15; req = 4'b0010; req_data_en = '1; fifo_data_ack = 1'b1;
    push_burst(1, 2);
    cyc();
    tests++;
    if (gnt !== 4'b0010) begin fails++; $display("FAIL rstmid_gnt: got %b, required 0010", gnt); end
    req = '0;
    cyc(); cyc();
    reset_n = 1'b0;
    #1;
    tests++;
    if ((gnt !== '0) || (fifo_data_en !== 1'b0) || (req_data_ack !== '0) || (fifo_data !== '0)) begin
      fails++;
      $display("FAIL rstmid_immediate: gnt=%b en=%b ack=%b data=%h, required all zero",
               gnt, fifo_data_en, req_data_ack, fifo_data);
    end
    for (int k = 0; k < 2; k++) begin
      cyc();
      tests++;
      if (req_done !== '0) begin fails++; $display("FAIL rstmid_no_done_c%0d: got %b, required 0000", k, req_done); end
    end
    set_len(0, 1); set_len(1, 1); req = 4'b0011;
    push_burst(0, 1); push_burst(1, 1);
    reset_n = 1'b1;
    cyc();
    tests++;
    if (gnt !== 4'b0001) begin fails++; $display("FAIL rstmid_first_grant: got %b, required 0001", gnt); end
    req = 4'b0010;
    t = 0;
    while ((gnt !== 4'b0010) && (t < 10)) begin cyc(); t++; end
    tests++;
    if (gnt !== 4'b0010) begin fails++; $display("FAIL rstmid_second_grant: got %b, required 0010", gnt); end
    req = '0;
    repeat (4) cyc();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: %0d words left, required 0", exp_q.size());
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin word_idx[i] = 0; pushed[i] = 0; end
    reset_n = 1'b0; req = '0; req_len = '0; req_data_en = '0;
    fifo_avail = '0; fifo_data_ack = 1'b1;
    fork
      monitor();
    join_none
    test_reset();
    test_single_burst();
    test_round_robin();
    test_space_gating();
    test_illegal_len();
    test_stalls();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
